// File: rtl/divider_arbiter_pkg.sv
// rtl/divider_arbiter_pkg.sv - shared widths, constants and FSM encoding for divider_arbiter
package divider_arbiter_pkg;

    localparam int DIVIDEND_W = 11;
    localparam int SIGMA_W    = 14;
    localparam logic [DIVIDEND_W-1:0] DZ_QUOTIENT = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/divider.sv
// rtl/divider.sv - combinational unsigned truncating divider with divide-by-zero flag
module divider
    import divider_arbiter_pkg::*;
(
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [SIGMA_W-1:0]    sigma,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  dz
);

    logic [SIGMA_W-1:0] dividend_wide;
    logic [SIGMA_W-1:0] quotient_wide;

    // Divide at the divisor width; the dividend is narrower, so the result always fits back.
    assign dividend_wide = {{(SIGMA_W-DIVIDEND_W){1'b0}}, dividend};
    assign dz            = (sigma == '0);
    assign quotient_wide = dz ? '0 : (dividend_wide / sigma);
    assign quotient      = dz ? DZ_QUOTIENT : DIVIDEND_W'(quotient_wide);

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant, search starts at ptr
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// rtl/divider_arbiter.sv - shares one divider among N_REQ requesters with round-robin grant
module divider_arbiter
    import divider_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DIVIDEND_W-1:0]   req_dividend,
    input  logic [N_REQ*SIGMA_W-1:0]      req_sigma,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          res_valid,
    output logic [ID_W-1:0]               res_id,
    output logic [DIVIDEND_W-1:0]         res_data,
    output logic                          res_dz,
    input  logic                          res_ready,
    output logic                          busy
);

    state_t                state;
    state_t                state_next;
    logic [ID_W-1:0]       rr_ptr;
    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       gid;
    logic [DIVIDEND_W-1:0] sel_dividend;
    logic [SIGMA_W-1:0]    sel_sigma;
    logic [DIVIDEND_W-1:0] op_dividend;
    logic [SIGMA_W-1:0]    op_sigma;
    logic [DIVIDEND_W-1:0] quotient;
    logic                  dz;
    logic                  transfer;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    divider u_divider (
        .dividend (op_dividend),
        .sigma    (op_sigma),
        .quotient (quotient),
        .dz       (dz)
    );

    always_comb begin
        gid          = '0;
        sel_dividend = '0;
        sel_sigma    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gid          = ID_W'(i);
                sel_dividend = req_dividend[i*DIVIDEND_W +: DIVIDEND_W];
                sel_sigma    = req_sigma[i*SIGMA_W +: SIGMA_W];
            end
        end
    end

    // Grant only reaches requesters while idle, so a transfer can only start from IDLE.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        transfer   = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = grant;
                transfer  = |grant;
                if (|grant) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                state_next = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            op_dividend <= '0;
            op_sigma    <= '0;
            res_id      <= '0;
            res_data    <= '0;
            res_dz      <= 1'b0;
        end else begin
            if (transfer) begin
                op_dividend <= sel_dividend;
                op_sigma    <= sel_sigma;
                res_id      <= gid;
                rr_ptr      <= (gid == ID_W'(N_REQ-1)) ? '0 : gid + 1'b1;
            end
            if (state == CALC) begin
                res_data <= quotient;
                res_dz   <= dz;
            end
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// tb/tb_divider_arbiter.sv - directed and randomized checks of divider_arbiter against a behavioural model
module tb_divider_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*11-1:0] req_dividend;
    logic [N*14-1:0] req_sigma;
    logic [N-1:0]  req_ready;
    logic          res_valid;
    logic [1:0]    res_id;
    logic [10:0]   res_data;
    logic          res_dz;
    logic          res_ready;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;

    divider_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_dividend (req_dividend),
        .req_sigma    (req_sigma),
        .req_ready    (req_ready),
        .res_valid    (res_valid),
        .res_id       (res_id),
        .res_data     (res_data),
        .res_dz       (res_dz),
        .res_ready    (res_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int dvd, input int sig);
        req_dividend[i*11 +: 11] = 11'(dvd);
        req_sigma[i*14 +: 14]    = 14'(sig);
    endtask

    task automatic random_ops();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0)
                set_ops(i, $urandom_range(0, 2047), 0);
            else if ($urandom_range(0, 1) == 0)
                set_ops(i, $urandom_range(0, 2047), $urandom_range(1, 40));
            else
                set_ops(i, $urandom_range(0, 2047), $urandom_range(1, 16383));
        end
    endtask

    // One full request/response round; expectations come from the round-robin and division rules.
    task automatic txn(input logic [N-1:0] vmask, input int hold);
        int          gi;
        int          ed;
        int          es;
        logic [10:0] eq;
        logic        edz;
        logic [N-1:0] eg;
        gi = -1;
        for (int k = 0; k < N; k++)
            if (gi < 0 && vmask[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        req_valid = vmask;
        res_ready = (hold == 0);
        #1;
        check("grant", req_ready, eg);
        if (gi < 0) begin
            tick();
            check("idle_busy", busy, 0);
            return;
        end
        ed  = int'(req_dividend[gi*11 +: 11]);
        es  = int'(req_sigma[gi*14 +: 14]);
        edz = (es == 0);
        eq  = edz ? 11'h7FF : 11'(ed / es);
        m_ptr = (gi + 1) % N;
        tick();
        req_valid = 4'($urandom);
        random_ops();
        #1;
        check("calc_busy", busy, 1);
        check("calc_ready", req_ready, 0);
        check("calc_valid", res_valid, 0);
        tick();
        check("resp_valid", res_valid, 1);
        check("resp_id", res_id, gi);
        check("resp_data", res_data, eq);
        check("resp_dz", res_dz, edz);
        for (int h = 0; h < hold; h++) begin
            req_valid = 4'($urandom);
            random_ops();
            tick();
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, eq);
            check("hold_id", res_id, gi);
            check("hold_dz", res_dz, edz);
            check("hold_ready", req_ready, 0);
            check("hold_busy", busy, 1);
        end
        res_ready = 1'b1;
        tick();
        check("back_idle", busy, 0);
        check("back_valid", res_valid, 0);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_sigma    = '0;
        res_ready    = 1'b0;
        tick();
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", res_data, 0);
        check("rst_id", res_id, 0);
        check("rst_dz", res_dz, 0);
        rst = 1'b0;
        tick();

        set_ops(0, 1000, 7);
        txn(4'b0001, 0);
        check("single_q", res_data, 142);

        set_ops(2, 500, 0);
        txn(4'b0100, 0);

        set_ops(1, 1234, 3);
        txn(4'b0010, 5);

        // Drop a request before the edge: no grant, no state change, pointer kept.
        req_valid = 4'b0100;
        #1;
        check("drop_grant", req_ready, 4'b0100);
        req_valid = 4'b0000;
        tick();
        check("drop_busy", busy, 0);
        txn(4'b1111, 0);

        set_ops(3, 2047, 1);
        txn(4'b1000, 0);
        set_ops(1, 5, 16383);
        txn(4'b0010, 0);

        // Reset while a result is being presented.
        set_ops(3, 900, 9);
        req_valid = 4'b1000;
        res_ready = 1'b0;
        tick();
        tick();
        check("pre_rst_valid", res_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", res_data, 0);
        check("mid_rst_id", res_id, 0);
        req_valid = '0;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        tick();
        check("post_rst_valid", res_valid, 0);
        txn(4'b0011, 0);

        // Reset during CALC must discard the in-flight result.
        req_valid = 4'b0100;
        tick();
        rst = 1'b1;
        #1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        tick();
        check("calc_rst_valid", res_valid, 0);
        check("calc_rst_busy", busy, 0);

        for (int r = 0; r < 5; r++) begin
            random_ops();
            txn(4'b1111, 0);
        end

        for (int r = 0; r < 30; r++) begin
            random_ops();
            txn(4'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
